// File: rtl/spart_tx_arb.sv
// Round-robin arbiter feeding one SPART transmitter from N_REQ byte requesters.
// Multi-byte messages lock the grant to their owner until the last byte or an idle timeout.
module spart_tx_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LOCK_TO = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           ack,
  input  logic                       TBR,
  output logic                       tx_write,
  output logic [7:0]                 tx_data,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       lock_active,
  output logic                       busy,
  output logic                       lock_timeout
);

  localparam int unsigned IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ARB,
    WAIT_LO,
    WAIT_HI
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            lock_q, lock_d;
  logic [7:0]      idle_q, idle_d;
  logic            to_q, to_d;

  logic [N_REQ-1:0] eligible;
  logic [IW-1:0]    win;
  logic             found;
  logic             grant;

  // Circular search starting one past the last message winner.
  always_comb begin
    eligible = lock_q ? (req & (N_REQ'(1) << owner_q)) : req;
    found    = 1'b0;
    win      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned idx;
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // Gated by rst_n so no strobe can leak out while reset is held.
  assign grant    = rst_n && (state_q == ARB) && TBR && found;
  assign tx_write = grant;
  assign ack      = grant ? (N_REQ'(1) << win) : '0;
  assign tx_data  = grant ? req_data[8*int'(win) +: 8] : '0;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    idle_d  = idle_q;
    to_d    = 1'b0;
    case (state_q)
      ARB: begin
        if (grant) begin
          state_d = WAIT_LO;
          owner_d = win;
          idle_d  = '0;
          if (req_last[win]) begin
            lock_d = 1'b0;
            rr_d   = win;
          end else begin
            lock_d = 1'b1;
          end
        end else if (lock_q && TBR && !req[owner_q]) begin
          if (idle_q + 8'd1 == 8'(LOCK_TO)) begin
            lock_d = 1'b0;
            to_d   = 1'b1;
            rr_d   = owner_q;
            idle_d = '0;
          end else begin
            idle_d = idle_q + 8'd1;
          end
        end
      end
      WAIT_LO: if (!TBR) state_d = WAIT_HI;
      WAIT_HI: if (TBR)  state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      rr_q    <= IW'(N_REQ - 1);
      owner_q <= '0;
      lock_q  <= 1'b0;
      idle_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      idle_q  <= idle_d;
      to_q    <= to_d;
    end
  end

  assign owner        = owner_q;
  assign lock_active  = lock_q;
  assign busy         = (state_q != ARB);
  assign lock_timeout = to_q;

endmodule

// File: tb/tb_spart_tx_arb.sv
// Directed bench for spart_tx_arb; instance uses LOCK_TO=4 so the timeout path is reachable.
module tb_spart_tx_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  ack;
  logic        TBR;
  logic        tx_write;
  logic [7:0]  tx_data;
  logic [1:0]  owner;
  logic        lock_active;
  logic        busy;
  logic        lock_timeout;

  int unsigned vectors;
  int unsigned miscompares;

  logic [3:0] s_ack;
  logic       s_txw;
  logic [7:0] s_txd;
  logic [1:0] s_owner;
  logic       s_lock;
  logic       s_busy;
  logic       s_to;

  spart_tx_arb #(.N_REQ(4), .LOCK_TO(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .req_last     (req_last),
    .ack          (ack),
    .TBR          (TBR),
    .tx_write     (tx_write),
    .tx_data      (tx_data),
    .owner        (owner),
    .lock_active  (lock_active),
    .busy         (busy),
    .lock_timeout (lock_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, capture outputs mid-cycle, advance past the edge.
  task automatic cyc(input logic tbr, input logic [3:0] r, input logic [3:0] l);
    TBR = tbr; req = r; req_last = l;
    #1;
    s_ack = ack; s_txw = tx_write; s_txd = tx_data; s_owner = owner;
    s_lock = lock_active; s_busy = busy; s_to = lock_timeout;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; TBR = 1'b1; req = 4'b1111; req_last = 4'b1111; req_data = 32'hA3A2A1A0;
    @(posedge clk); #1;
    vectors++; if ({tx_write, ack, tx_data} !== 13'h0) begin
      miscompares++; $display("FAIL reset_tx: got txw=%b ack=%b txd=%h want 0/0000/00", tx_write, ack, tx_data); end
    vectors++; if ({busy, lock_timeout, lock_active, owner} !== 5'b0) begin
      miscompares++; $display("FAIL reset_state: got busy=%b to=%b lock=%b owner=%0d want all 0", busy, lock_timeout, lock_active, owner); end
    req = 4'b0000;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 4'b0000, 4'b0000);
    vectors++; if ({s_txw, s_ack, s_busy} !== 6'b0) begin
      miscompares++; $display("FAIL idle_arb: got txw=%b ack=%b busy=%b want 0", s_txw, s_ack, s_busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_w [5];
    exp_w = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req_data = 32'hA3A2A1A0;
    for (int g = 0; g < 5; g++) begin
      cyc(1'b1, 4'b1111, 4'b1111);
      vectors++; if (s_ack !== (4'b0001 << exp_w[g]) || s_txw !== 1'b1 || s_txd !== (8'hA0 + 8'(exp_w[g]))) begin
        miscompares++; $display("FAIL rr_grant%0d: got ack=%b txw=%b txd=%h want ack=%b txd=%h",
          g, s_ack, s_txw, s_txd, 4'b0001 << exp_w[g], 8'hA0 + 8'(exp_w[g])); end
      cyc(1'b0, 4'b1111, 4'b1111);
      vectors++; if (s_ack !== 4'b0 || s_txw !== 1'b0 || s_busy !== 1'b1 || s_owner !== exp_w[g] || s_lock !== 1'b0) begin
        miscompares++; $display("FAIL rr_waitlo%0d: got ack=%b txw=%b busy=%b owner=%0d lock=%b want 0/0/1/%0d/0",
          g, s_ack, s_txw, s_busy, s_owner, s_lock, exp_w[g]); end
      cyc(1'b1, 4'b1111, 4'b1111);
      vectors++; if (s_ack !== 4'b0 || s_txw !== 1'b0 || s_busy !== 1'b1) begin
        miscompares++; $display("FAIL rr_waithi%0d: got ack=%b txw=%b busy=%b want 0/0/1", g, s_ack, s_txw, s_busy); end
    end
  endtask

  task automatic test_lock();
    logic [7:0] bytes [3];
    bytes = '{8'hC1, 8'hC2, 8'hC3};
    for (int b = 0; b < 3; b++) begin
      req_data = {8'h00, bytes[b], 8'h00, 8'h50};
      cyc(1'b1, 4'b0101, (b == 2) ? 4'b0100 : 4'b0000);
      vectors++; if (s_ack !== 4'b0100 || s_txd !== bytes[b]) begin
        miscompares++; $display("FAIL lock_byte%0d: got ack=%b txd=%h want 0100/%h", b, s_ack, s_txd, bytes[b]); end
      cyc(1'b0, 4'b0101, 4'b0000);
      vectors++; if (s_lock !== (b != 2) || s_owner !== 2'd2) begin
        miscompares++; $display("FAIL lock_flag%0d: got lock=%b owner=%0d want %b/2", b, s_lock, s_owner, b != 2); end
      cyc(1'b1, 4'b0101, 4'b0000);
    end
    cyc(1'b1, 4'b0001, 4'b0001);
    vectors++; if (s_ack !== 4'b0001 || s_txd !== 8'h50) begin
      miscompares++; $display("FAIL lock_after: got ack=%b txd=%h want 0001/50", s_ack, s_txd); end
    cyc(1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0000, 4'b0000);
  endtask

  task automatic test_back_to_back();
    int unsigned extra;
    req_data = 32'h0000_1100;
    cyc(1'b1, 4'b0010, 4'b0010);
    vectors++; if (s_ack !== 4'b0010 || s_txd !== 8'h11) begin
      miscompares++; $display("FAIL hold_first: got ack=%b txd=%h want 0010/11", s_ack, s_txd); end
    req_data = 32'h0000_1200;
    extra = 0;
    for (int i = 0; i < 2; i++) begin cyc(1'b1, 4'b0010, 4'b0010); extra += s_txw; end
    for (int i = 0; i < 160; i++) begin cyc(1'b0, 4'b0010, 4'b0010); extra += s_txw; end
    cyc(1'b1, 4'b0010, 4'b0010); extra += s_txw;
    vectors++; if (extra !== 0) begin
      miscompares++; $display("FAIL hold_extra_writes: got %0d want 0", extra); end
    cyc(1'b1, 4'b0010, 4'b0010);
    vectors++; if (s_txw !== 1'b1 || s_ack !== 4'b0010 || s_txd !== 8'h12) begin
      miscompares++; $display("FAIL hold_second: got txw=%b ack=%b txd=%h want 1/0010/12", s_txw, s_ack, s_txd); end
    cyc(1'b0, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0000, 4'b0000);
  endtask

  task automatic test_timeout();
    req_data = 32'h3300_2100;
    cyc(1'b1, 4'b0010, 4'b0000);
    vectors++; if (s_ack !== 4'b0010) begin
      miscompares++; $display("FAIL to_grant1: got ack=%b want 0010", s_ack); end
    cyc(1'b0, 4'b0010, 4'b0000);
    cyc(1'b1, 4'b0010, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 4'b1000, 4'b1000);
      vectors++; if (s_ack !== 4'b0 || s_to !== 1'b0 || s_lock !== 1'b1) begin
        miscompares++; $display("FAIL to_idle%0d: got ack=%b to=%b lock=%b want 0000/0/1", i, s_ack, s_to, s_lock); end
    end
    cyc(1'b1, 4'b1000, 4'b1000);
    vectors++; if (s_to !== 1'b1 || s_lock !== 1'b0 || s_ack !== 4'b1000 || s_txd !== 8'h33) begin
      miscompares++; $display("FAIL to_release: got to=%b lock=%b ack=%b txd=%h want 1/0/1000/33", s_to, s_lock, s_ack, s_txd); end
    cyc(1'b0, 4'b0000, 4'b0000);
    vectors++; if (s_to !== 1'b0) begin
      miscompares++; $display("FAIL to_pulse_width: got to=%b want 0", s_to); end
    cyc(1'b1, 4'b0000, 4'b0000);
  endtask

  task automatic test_reset_mid();
    req_data = 32'h0000_4400;
    cyc(1'b1, 4'b0010, 4'b0000);
    cyc(1'b0, 4'b0010, 4'b0000);
    vectors++; if (busy !== 1'b1 || lock_active !== 1'b1) begin
      miscompares++; $display("FAIL rm_prelock: got busy=%b lock=%b want 1/1", busy, lock_active); end
    rst_n = 1'b0;
    #1;
    vectors++; if (lock_active !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rm_inreset: got lock=%b busy=%b want 0/0", lock_active, busy); end
    req_data = 32'h9900_0077;
    cyc(1'b1, 4'b1001, 4'b1001);
    vectors++; if (s_txw !== 1'b0 || s_ack !== 4'b0) begin
      miscompares++; $display("FAIL rm_nowrite: got txw=%b ack=%b want 0/0000", s_txw, s_ack); end
    rst_n = 1'b1;
    cyc(1'b1, 4'b1001, 4'b1001);
    vectors++; if (s_ack !== 4'b0001 || s_txd !== 8'h77 || s_lock !== 1'b0) begin
      miscompares++; $display("FAIL rm_first: got ack=%b txd=%h lock=%b want 0001/77/0", s_ack, s_txd, s_lock); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_lock();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spart_tx_arb.md
SPART_TX_ARB -- requirements
Module: spart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one SPART transmitter; fixed at 4 for this release.
REQ-002 Parameter LOCK_TO, default 255, idle cycles an owner may hold a message lock before forced release; range 1-255.
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  per-requester byte-valid; held until ack.
REQ-006 req_data  input  32  bytes, requester i on bits [8i+7:8i].
REQ-007 req_last  input  4  per-requester end-of-message flag, qualified with req.
REQ-008 ack  output  4  one-hot, one-cycle byte-accepted pulse.
REQ-009 TBR  input  1  transmit buffer ready from transmitter.
REQ-010 tx_write  output  1  one-cycle load strobe to transmitter.
REQ-011 tx_data  output  8  byte to transmitter; 8'h00 when tx_write=0.
REQ-012 owner  output  2  index of last granted requester.
REQ-013 lock_active  output  1  message lock held by owner.
REQ-014 busy  output  1  high in any state other than ARB.
REQ-015 lock_timeout  output  1  one-cycle pulse on forced lock release.

Function
REQ-016 FSM SHALL have states ARB, WAIT_LO, WAIT_HI.
REQ-017 ARB: when TBR=1 and an eligible request exists, SHALL assert tx_write, tx_data=req_data[winner], ack[winner] combinationally in that cycle, then go to WAIT_LO.
REQ-018 ARB with TBR=0 or no eligible request SHALL hold, with tx_write=0 and ack=0.
REQ-019 WAIT_LO SHALL stay until TBR=0, then go to WAIT_HI; TBR=1 in the cycle after the grant SHALL NOT cause a new grant.
REQ-020 WAIT_HI SHALL stay until TBR=1, then return to ARB; the next grant occurs no earlier than the following cycle.
REQ-021 Minimum spacing between consecutive tx_write pulses SHALL be 3 cycles.
REQ-022 Unlocked: eligible = all req bits; winner = first set bit searching circularly from (rr_ptr+1) mod 4.
REQ-023 rr_ptr SHALL update to winner only on a grant with req_last=1, so a message's priority slot is consumed once.
REQ-024 A grant with req_last=0 SHALL set lock_active=1 with owner=winner; while locked only req[owner] is eligible.
REQ-025 A grant from the owner with req_last=1 SHALL clear lock_active in the next cycle.
REQ-026 Idle counter (8-bit) SHALL count ARB cycles with lock_active=1, TBR=1 and req[owner]=0; it SHALL clear on any owner grant or when leaving lock.
REQ-027 Idle counter reaching LOCK_TO SHALL clear lock_active, pulse lock_timeout for one cycle, and set rr_ptr=owner; arbitration resumes unlocked in the next cycle.
REQ-028 Simultaneous requests SHALL produce exactly one ack; ack SHALL never assert outside ARB.
REQ-029 owner SHALL update on every grant and hold otherwise.
REQ-030 A requester dropping req without ack SHALL NOT be granted; a byte is never sent without the matching ack.

Reset
REQ-031 Reset SHALL force state=ARB, rr_ptr=3 (requester 0 has highest priority), owner=0, lock_active=0, idle counter=0.
REQ-032 During reset tx_write=0, tx_data=8'h00, ack=4'b0000, busy=0, lock_timeout=0.
REQ-033 Reset mid-transfer SHALL abandon any lock; no tx_write SHALL be issued until TBR=1 is sampled in ARB after reset release.

Verification
REQ-034 req=4'b1111, req_last=4'b1111, TBR model idle: grants SHALL follow 0,1,2,3,0 with tx_data = each req_data byte.
REQ-035 req[2] message of 3 bytes (last on byte 3) with req[0] constantly requesting: three consecutive acks to 2 with lock_active=1 until the third, then ack[0].
REQ-036 TBR held 1 for 2 cycles after a grant, then 0 for 160, then 1: only one tx_write SHALL occur; next tx_write 1 cycle after TBR returns to 1.
REQ-037 Locked owner 1 drops req, LOCK_TO=4, req[3]=1: lock_timeout pulse after 4 idle cycles, next grant to 3.
REQ-038 rst_n asserted in WAIT_HI while locked: after release, lock_active=0, and the first grant goes to requester 0 when req=4'b1001.
